// File: rtl/mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_drain
// Description : Snapshots the packed accumulator word of the precision-
//               scalable MAC on a capture strobe. It splits the word into its
//               per-lane sub-accumulators, sign-extends each lane to full
//               width and streams one lane per beat over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_drain #(
  parameter  int W_WIDTH         = 8,
  parameter  int A_WIDTH         = 8,
  parameter  int PLUS_WIDTH      = 4,
  parameter  int CONFIG_AW_WIDTH = 1,
  localparam int BLOCK_NB        = 2 ** CONFIG_AW_WIDTH,
  localparam int Z_WIDTH         = W_WIDTH + A_WIDTH + BLOCK_NB * PLUS_WIDTH,
  localparam int LANE_IDX_WIDTH  = CONFIG_AW_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,        // async, active-low
  input  logic                       capture,
  input  logic [CONFIG_AW_WIDTH-1:0] config_aw,
  input  logic [Z_WIDTH-1:0]         z,
  output logic                       cap_ready,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [Z_WIDTH-1:0]         r_data,
  output logic [LANE_IDX_WIDTH-1:0]  r_lane,
  output logic                       r_last,
  output logic                       overrun
);

  // log2 of the lane count; ranges 0..CONFIG_AW_WIDTH
  localparam int c_LG_W = $clog2(CONFIG_AW_WIDTH + 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  logic [0:0]                r_state;
  logic [Z_WIDTH-1:0]        r_z;
  logic [c_LG_W-1:0]         r_lg;
  logic [LANE_IDX_WIDTH-1:0] r_cnt;
  logic                      r_ovr;

  logic                      w_send;
  logic                      w_is_last;
  logic                      w_accept;
  logic [c_LG_W-1:0]         w_cap_lg;
  logic [LANE_IDX_WIDTH-1:0] w_last_idx;
  logic [Z_WIDTH-1:0]        w_mode_lane [0:CONFIG_AW_WIDTH];

  // Clamp the requested lane count to the number of physical blocks
  always_comb begin
    w_cap_lg = c_LG_W'(CONFIG_AW_WIDTH);
    if (int'(config_aw) < CONFIG_AW_WIDTH) w_cap_lg = c_LG_W'(config_aw);
  end

  // Index of the final lane of the captured word: L-1
  always_comb begin
    w_last_idx = LANE_IDX_WIDTH'((32'd1 << r_lg) - 32'd1);
  end

  // One sign-extended candidate per precision mode, all from captured state
  for (genvar g = 0; g <= CONFIG_AW_WIDTH; g++) begin : g_mode
    localparam int LW = Z_WIDTH >> g;
    if (g == 0) begin : g_full
      assign w_mode_lane[g] = r_z;
    end else begin : g_split
      logic [LW-1:0] w_lane;
      assign w_lane         = LW'(r_z >> (LW * int'(r_cnt)));
      assign w_mode_lane[g] = {{(Z_WIDTH - LW){w_lane[LW-1]}}, w_lane};
    end
  end

  assign w_send    = (r_state == c_SEND);
  assign w_is_last = (r_cnt == w_last_idx);
  assign cap_ready = !w_send || (r_ready && w_is_last);
  assign w_accept  = capture && cap_ready;

  // Outputs are decoded from registered state only; quiet while idle
  assign r_valid = w_send;
  assign r_lane  = w_send ? r_cnt : '0;
  assign r_last  = w_send && w_is_last;
  assign r_data  = w_send ? w_mode_lane[r_lg] : '0;
  assign overrun = r_ovr;

  // Capture/stream state machine with lane counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_z     <= '0;
      r_lg    <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= c_SEND;
      r_z     <= z;
      r_lg    <= w_cap_lg;
      r_cnt   <= '0;
    end else if (w_send && r_ready) begin
      if (w_is_last) begin
        r_state <= c_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // Sticky flag for captures dropped while a word is still draining
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr <= 1'b0;
    end else if (capture && !cap_ready) begin
      r_ovr <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/mac_result_drain.md
# mac_result_drain

Output-side companion of the multiplexed precision-scalable MAC. On a capture strobe it snapshots the packed accumulator word `z` together with the `config_aw` in effect. It then splits the word into its per-lane sub-accumulators, sign-extends each lane to full width, and streams them out one lane per beat over a valid/ready handshake. It sits between the MAC output and the result collection logic.

## Interface
Parameters:
- W_WIDTH, 8, weight operand width of the attached MAC; must be a multiple of BLOCK_NB.
- A_WIDTH, 8, activation operand width; must be a multiple of BLOCK_NB.
- PLUS_WIDTH, 4, guard bits per accumulator block.
- CONFIG_AW_WIDTH, 1, precision config width; BLOCK_NB = 2**CONFIG_AW_WIDTH.
- Derived: Z_WIDTH = W_WIDTH+A_WIDTH+BLOCK_NB*PLUS_WIDTH; LANE_IDX_WIDTH = CONFIG_AW_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assertion, active-low (0 = reset).
- capture  in  1  strobe: snapshot `z` and `config_aw` this cycle.
- config_aw  in  CONFIG_AW_WIDTH  precision mode of the word being captured.
- z  in  Z_WIDTH  packed accumulator word from the MAC.
- cap_ready  out  1  high when a capture is accepted this cycle.
- r_valid  out  1  lane beat valid.
- r_ready  in  1  downstream accepts beat.
- r_data  out  Z_WIDTH  sign-extended lane value.
- r_lane  out  LANE_IDX_WIDTH  lane index of current beat.
- r_last  out  1  current beat is the final lane of the word.
- overrun  out  1  sticky: a capture was dropped.

## Operation
- Lane count L = min(2**config_aw, BLOCK_NB), latched at capture. Lane width LW = Z_WIDTH/L.
- Lane i = captured z[i*LW +: LW], sign-extended from bit LW-1 to Z_WIDTH. Lane 0 (LSBs) is sent first.
- FSM has two states: IDLE and SEND.
  - IDLE: cap_ready=1, r_valid=0. When capture=1: latch z, latch L, lane counter=0, go to SEND.
  - SEND: r_valid=1, r_data = lane[counter], r_lane = counter, r_last = (counter == L-1).
  - SEND, r_valid & r_ready & !r_last: counter+1.
  - SEND, r_valid & r_ready & r_last: go to IDLE. If capture=1 in the same cycle, it is accepted instead: relatch, counter=0, stay in SEND.
  - SEND, otherwise: hold all outputs.
- cap_ready = IDLE | (SEND & r_valid & r_ready & r_last). This signal is combinational.
- A capture with cap_ready=0 is ignored. The captured data is unaffected, and overrun is set to 1 and holds until reset.
- While r_valid=1 and r_ready=0, r_data, r_lane and r_last are held stable. r_valid never deasserts without a handshake.
- config_aw and z are sampled only on an accepted capture. Changes at any other time have no effect.

## Timing
- Reset values (asynchronous, while rst=0): FSM=IDLE, r_valid=0, r_data=0, r_lane=0, r_last=0, overrun=0, counter=0, capture registers=0.
- Reset mid-transfer aborts immediately. Any remaining lanes are lost and are not resumed after release.
- Latency: the first beat is valid in the cycle after the capture edge.
- Throughput: one lane per cycle while r_ready=1. A word of L lanes occupies L cycles.
- A back-to-back capture on the last handshake gives no bubble: the next word's lane 0 follows the next cycle.
- r_data, r_lane and r_last are registered or muxed from registered state only. There is no combinational path from z or config_aw to outputs.
- cap_ready depends combinationally on r_ready during the last beat only.

## Test plan
All cases use defaults: Z_WIDTH=24, BLOCK_NB=2.
- Single lane: config_aw=0, z=24'hFFFFFE, capture, r_ready=1. Expect one beat next cycle: r_data=24'hFFFFFE, r_lane=0, r_last=1; then r_valid=0.
- Two lanes: config_aw=1, z=24'h805003, r_ready=1. Expect beat 1: r_data=24'h000003, r_lane=0, r_last=0. Expect beat 2: r_data=24'hFFF805, r_lane=1, r_last=1.
- Backpressure: two-lane case with r_ready=0 for 3 cycles after r_valid rises. Expect r_data=24'h000003 and r_lane=0 held for all 3 cycles, then normal completion.
- Overrun: capture z=24'h001002 (config_aw=1), then capture z=24'h7FF7FF during lane 0. Expect overrun=1 and held; the beats stay 24'h000002 then 24'h000001.
- Back-to-back: capture a second word (config_aw=0, z=24'h000010) in the cycle of the first word's last handshake. Expect r_valid to stay high and the next cycle r_data=24'h000010, r_last=1.
- Async reset: drop rst mid-way through lane 0 with r_ready=0. Expect r_valid=0, r_data=0 and overrun=0 immediately, without a clock edge. Expect IDLE and cap_ready=1 after release.
